lut_sweep_n: RTL

LUT_SWEEP_N -- requirements
Module: lut_sweep_n

---
 rtl/lut_sweep_n.sv | 58 +++++
 1 files changed

// File: rtl/lut_sweep_n.sv
// lut_sweep_n: serially loaded N-input LUT with a registered lookup and a full-table minterm-count sweep
module lut_sweep_n #(
  parameter int N = 6,
  parameter int DEPTH = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         load,
  input  logic         load_bit,
  input  logic         start,
  output logic         y,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_cnt
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, next_state;
  logic [DEPTH-1:0] tt;
  logic [N-1:0] idx;
  logic [N:0] acc, bit_ext;
  logic last, go, shift;
  assign bit_ext = {{N{1'b0}}, tt[idx]};
  assign last = &idx;
  assign shift = state == IDLE && load;
  // load takes priority over start; a colliding start is simply dropped
  assign go = state == IDLE && start && !load;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (go ? SWEEP : IDLE) :
                 state == SWEEP ? (last ? DONE : SWEEP) : IDLE;
  always_comb begin
    busy = state == SWEEP;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      tt <= '0;
      idx <= '0;
      acc <= '0;
      y <= 1'b0;
      ones_cnt <= '0;
    end else begin
      y <= tt[in];
      if (shift) tt <= {tt[DEPTH-2:0], load_bit};
      if (go) begin
        idx <= '0;
        acc <= '0;
      end
      if (state == SWEEP) begin
        acc <= acc + bit_ext;
        idx <= last ? '0 : idx + N'(1);
        if (last) ones_cnt <= acc + bit_ext;
      end
    end
endmodule
